// File: rtl/conf_int_mac_job_sched_if.sv
// Requester-side bus of the MAC job scheduler: job requests, operand stream and tagged result.
interface conf_int_mac_job_sched_if #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned DW    = 32,
    parameter int unsigned LEN_W = 8,
    parameter int unsigned ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]       req_start;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       op_valid;
    logic [NREQ*DW-1:0]    op_a;
    logic [NREQ*DW-1:0]    op_b;
    logic [NREQ-1:0]       op_ready;
    logic                  res_valid;
    logic [ID_W-1:0]       res_id;
    logic [DW-1:0]         res_data;
    logic                  res_ready;

    modport master (
        output req_start, req_len, op_valid, op_a, op_b, res_ready,
        input  grant, op_ready, res_valid, res_id, res_data
    );

    modport slave (
        input  req_start, req_len, op_valid, op_a, op_b, res_ready,
        output grant, op_ready, res_valid, res_id, res_data
    );
endinterface

// File: rtl/conf_int_mac_job_sched.sv
// Round-robin job scheduler sharing one MAC datapath between NREQ requesters.
// Each job clears the MAC, streams LEN operand pairs, drains and returns a tagged dot product.
module conf_int_mac_job_sched #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned DW      = 32,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned MAC_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    conf_int_mac_job_sched_if.slave     bus,
    output logic                        mac_racc,
    output logic                        mac_rapx,
    output logic [DW-1:0]               mac_a,
    output logic [DW-1:0]               mac_b,
    input  logic [DW-1:0]               mac_d
);
    localparam int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned DRW  = $clog2(MAC_LAT + 2);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_nx;
    logic [ID_W-1:0]   ptr_q, ptr_nx, owner_q, owner_nx, winner;
    logic [LEN_W-1:0]  len_q, len_nx, cnt_q, cnt_nx;
    logic [DRW-1:0]    dcnt_q, dcnt_nx;
    logic              found, xfer;
    logic [NREQ-1:0]   grant_q, grant_nx, op_ready_q, op_ready_nx;
    logic              racc_q, racc_nx, rapx_q, rapx_nx;
    logic [DW-1:0]     mac_a_q, mac_a_nx, mac_b_q, mac_b_nx;
    logic              res_valid_q, res_valid_nx;
    logic [ID_W-1:0]   res_id_q, res_id_nx;
    logic [DW-1:0]     res_data_q, res_data_nx;

    // Next-state and next-output decode; outputs are registered from these values.
    always_comb begin
        state_nx    = state_q;
        ptr_nx      = ptr_q;
        owner_nx    = owner_q;
        len_nx      = len_q;
        cnt_nx      = cnt_q;
        dcnt_nx     = dcnt_q;
        res_id_nx   = res_id_q;
        res_data_nx = res_data_q;
        grant_nx    = '0;
        op_ready_nx = '0;
        mac_a_nx    = '0;
        mac_b_nx    = '0;
        found       = 1'b0;
        winner      = '0;
        xfer        = op_ready_q[owner_q] & bus.op_valid[owner_q];

        // First pending request at or after the pointer, wrapping around.
        for (int k = 0; k < int'(NREQ); k++) begin
            if (!found && bus.req_start[(int'(ptr_q) + k) % int'(NREQ)]) begin
                found  = 1'b1;
                winner = ID_W'((int'(ptr_q) + k) % int'(NREQ));
            end
        end

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_nx[winner] = 1'b1;
                    owner_nx         = winner;
                    len_nx           = bus.req_len[int'(winner)*LEN_W +: LEN_W];
                    ptr_nx           = (winner == ID_W'(NREQ - 1)) ? '0 : winner + ID_W'(1);
                    state_nx         = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_nx   = '0;
                dcnt_nx  = '0;
                state_nx = (len_q == '0) ? S_DRAIN : S_FEED;
            end
            S_FEED: begin
                if (xfer) begin
                    mac_a_nx = bus.op_a[int'(owner_q)*DW +: DW];
                    mac_b_nx = bus.op_b[int'(owner_q)*DW +: DW];
                    cnt_nx   = cnt_q + LEN_W'(1);
                    if (cnt_nx == len_q) state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (dcnt_q == DRW'(MAC_LAT)) begin
                    res_data_nx = mac_d;
                    res_id_nx   = owner_q;
                    state_nx    = S_DONE;
                end else begin
                    dcnt_nx = dcnt_q + DRW'(1);
                end
            end
            S_DONE: begin
                if (bus.res_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase

        if (state_nx == S_FEED && cnt_nx < len_q) op_ready_nx[owner_nx] = 1'b1;
        racc_nx      = (state_nx != S_CLEAR);
        rapx_nx      = (state_nx != S_CLEAR);
        res_valid_nx = (state_nx == S_DONE);
    end

    // State and registered outputs; reset holds the MAC cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            dcnt_q      <= '0;
            grant_q     <= '0;
            op_ready_q  <= '0;
            racc_q      <= 1'b0;
            rapx_q      <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_nx;
            ptr_q       <= ptr_nx;
            owner_q     <= owner_nx;
            len_q       <= len_nx;
            cnt_q       <= cnt_nx;
            dcnt_q      <= dcnt_nx;
            grant_q     <= grant_nx;
            op_ready_q  <= op_ready_nx;
            racc_q      <= racc_nx;
            rapx_q      <= rapx_nx;
            mac_a_q     <= mac_a_nx;
            mac_b_q     <= mac_b_nx;
            res_valid_q <= res_valid_nx;
            res_id_q    <= res_id_nx;
            res_data_q  <= res_data_nx;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.op_ready  = op_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_data  = res_data_q;
    assign mac_racc      = racc_q;
    assign mac_rapx      = rapx_q;
    assign mac_a         = mac_a_q;
    assign mac_b         = mac_b_q;
endmodule
